// File: rtl/core_if_bp_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and instruction memory (slave).
interface core_if_bp_if;
    // Handshake: the master drives imem_addr with imem_req=1; the slave raises imem_rdy in the
    // same cycle once imem_rdata holds the word at imem_addr. req && !rdy retries the same address;
    // imem_rdy is ignored whenever imem_req is 0.
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_rdy;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, output imem_req, input imem_rdy, input imem_rdata);
    modport slave  (input imem_addr, input imem_req, output imem_rdy, output imem_rdata);
endinterface

// File: rtl/core_if_bp.sv
// Fetch stage with BTB, BHR-indexed 2-bit PHT and (with CORE_IF_RAS_EN defined) a return-address
// stack; drives the IF/ID register consumed by decode.
module core_if_bp #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    core_if_bp_if.master imem,
    input  logic         stall_pipeline_alu,
    input  logic         stall_pipeline_br,
    input  logic         if_flush,
    input  logic         update_btb_target_out,
    input  logic [31:0]  btb_target_out,
    input  logic [1:0]   btb_type_out,
    input  logic         update_BP_out,
    input  logic         taken,
    input  logic [1:0]   delayed_PHT_out,
    input  logic [2:0]   delayed_BHR_out,
    input  logic         recover_push,
    input  logic [31:0]  recover_push_addr,
    input  logic         recover_pop,
    output logic [31:0]  if_id_inst_word,
    output logic [31:0]  if_id_plus_4,
    output logic         btb_v,
    output logic [1:0]   btb_type,
    output logic [31:0]  pred_target,
    output logic [1:0]   delayed_PHT,
    output logic [2:0]   delayed_BHR
);

    localparam int          BTB_N     = 1 << BTB_IDX_W;
    localparam int          TAG_W     = 30 - BTB_IDX_W;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        stall;
    logic        advance;

    logic [BTB_N-1:0] btb_valid;
    logic [TAG_W-1:0] btb_tag [BTB_N];
    logic [1:0]       btb_typ [BTB_N];
    logic [31:0]      btb_tgt [BTB_N];

    logic [1:0] pht [8];
    logic [2:0] bhr;
    logic [1:0] pht_next;

    logic [BTB_IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic [29:0]          pc_id_word;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0]     wr_tag;

    logic        hit;
    logic [1:0]  rd_type;
    logic [1:0]  p;
    logic        predict_taken;
    logic [31:0] pred_tgt_raw;
    logic [31:0] pred_tgt;

    assign stall     = stall_pipeline_alu | stall_pipeline_br;
    assign advance   = !stall && !if_flush && imem.imem_rdy;
    assign pc_plus_4 = pc + 32'd4;

    assign imem.imem_addr = pc;
    assign imem.imem_req  = rst && !stall;

    // Lookup with the fetch pc.
    assign rd_idx        = pc[BTB_IDX_W+1:2];
    assign rd_tag        = pc[31:BTB_IDX_W+2];
    assign hit           = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign rd_type       = btb_typ[rd_idx];
    assign p             = pht[bhr];
    assign predict_taken = hit && ((rd_type != 2'b00) || p[1]);
    assign pred_tgt      = pred_tgt_raw & WORD_MASK;

    // The instruction in ID is addressed by its pc+4 minus one word.
    assign pc_id_word = if_id_plus_4[31:2] - 30'd1;
    assign wr_idx     = pc_id_word[BTB_IDX_W-1:0];
    assign wr_tag     = pc_id_word[29:BTB_IDX_W];

`ifdef CORE_IF_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      ras [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [PTR_W-1:0] nxt_ptr;
    logic [CNT_W-1:0] nxt_cnt;
    logic             wr0_en;
    logic [PTR_W-1:0] wr0_idx;
    logic             wr1_en;
    logic [PTR_W-1:0] wr1_idx;
    logic             fetch_push;
    logic             fetch_pop;
    logic             recover_ok;

    assign pred_tgt_raw = ((rd_type == 2'b11) && (ras_cnt != '0)) ? ras[ras_ptr - 1'b1]
                                                                   : btb_tgt[rd_idx];
    assign fetch_push   = advance && predict_taken && (rd_type == 2'b10);
    assign fetch_pop    = advance && predict_taken && (rd_type == 2'b11);
    assign recover_ok   = !stall;

    // Ops apply in order: fetch push/pop, then recovery pop, then recovery push.
    always_comb begin
        nxt_ptr = ras_ptr;
        nxt_cnt = ras_cnt;
        wr0_en  = 1'b0;
        wr0_idx = ras_ptr;
        wr1_en  = 1'b0;
        wr1_idx = ras_ptr;
        if (fetch_push) begin
            wr0_en  = 1'b1;
            wr0_idx = nxt_ptr;
            nxt_ptr = nxt_ptr + 1'b1;
            nxt_cnt = (nxt_cnt == CNT_W'(RAS_DEPTH)) ? nxt_cnt : nxt_cnt + 1'b1;
        end
        if (fetch_pop && (nxt_cnt != '0)) begin
            nxt_ptr = nxt_ptr - 1'b1;
            nxt_cnt = nxt_cnt - 1'b1;
        end
        if (recover_ok && recover_pop && (nxt_cnt != '0)) begin
            nxt_ptr = nxt_ptr - 1'b1;
            nxt_cnt = nxt_cnt - 1'b1;
        end
        if (recover_ok && recover_push) begin
            wr1_en  = 1'b1;
            wr1_idx = nxt_ptr;
            nxt_ptr = nxt_ptr + 1'b1;
            nxt_cnt = (nxt_cnt == CNT_W'(RAS_DEPTH)) ? nxt_cnt : nxt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            ras_ptr <= nxt_ptr;
            ras_cnt <= nxt_cnt;
        end
    end

    // The recovery write is later in program order, so it wins on a shared slot.
    always_ff @(posedge clk) begin
        if (wr0_en) ras[wr0_idx] <= pc_plus_4;
        if (wr1_en) ras[wr1_idx] <= recover_push_addr;
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_recover;

    assign unused_recover = ^{recover_push, recover_pop, recover_push_addr};
    assign pred_tgt_raw   = btb_tgt[rd_idx];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (update_btb_target_out) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (update_btb_target_out) begin
            btb_tag[wr_idx] <= wr_tag;
            btb_typ[wr_idx] <= btb_type_out;
            btb_tgt[wr_idx] <= btb_target_out;
        end
    end

    always_comb begin
        pht_next = delayed_PHT_out;
        if (taken) begin
            if (delayed_PHT_out != 2'b11) pht_next = delayed_PHT_out + 2'b01;
        end else begin
            if (delayed_PHT_out != 2'b00) pht_next = delayed_PHT_out - 2'b01;
        end
    end

    // Training comes from resolved branches in decode and is not held by a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) pht[i] <= 2'b01;
            bhr <= 3'b000;
        end else if (update_BP_out) begin
            pht[delayed_BHR_out] <= pht_next;
            bhr                  <= {bhr[1:0], taken};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc              <= RESET_PC;
            if_id_inst_word <= '0;
            if_id_plus_4    <= '0;
            btb_v           <= 1'b0;
            btb_type        <= '0;
            pred_target     <= '0;
            delayed_PHT     <= '0;
            delayed_BHR     <= '0;
        end else if (stall) begin
            pc <= pc;
        end else if (if_flush) begin
            pc              <= btb_target_out & WORD_MASK;
            if_id_inst_word <= '0;
            if_id_plus_4    <= '0;
            btb_v           <= 1'b0;
            btb_type        <= '0;
            pred_target     <= '0;
            delayed_PHT     <= '0;
            delayed_BHR     <= '0;
        end else if (!imem.imem_rdy) begin
            if_id_inst_word <= '0;
            if_id_plus_4    <= '0;
            btb_v           <= 1'b0;
            btb_type        <= '0;
            pred_target     <= '0;
            delayed_PHT     <= '0;
            delayed_BHR     <= '0;
        end else begin
            pc              <= predict_taken ? pred_tgt : pc_plus_4;
            if_id_inst_word <= imem.imem_rdata;
            if_id_plus_4    <= pc_plus_4;
            btb_v           <= hit;
            btb_type        <= rd_type;
            pred_target     <= pred_tgt;
            delayed_PHT     <= p;
            delayed_BHR     <= bhr;
        end
    end

endmodule

// File: tb/tb_core_if_bp.sv
// Self-checking bench for core_if_bp: sequential fetch, BTB redirect, stall/flush, imem wait,
// PHT training, pc wrap, jal/jr prediction (RAS when CORE_IF_RAS_EN is defined) and async reset.
module tb_core_if_bp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_pipeline_alu, stall_pipeline_br, if_flush;
    logic        update_btb_target_out;
    logic [31:0] btb_target_out;
    logic [1:0]  btb_type_out;
    logic        update_BP_out, taken;
    logic [1:0]  delayed_PHT_out;
    logic [2:0]  delayed_BHR_out;
    logic        recover_push, recover_pop;
    logic [31:0] recover_push_addr;
    logic [31:0] if_id_inst_word, if_id_plus_4, pred_target;
    logic        btb_v;
    logic [1:0]  btb_type, delayed_PHT;
    logic [2:0]  delayed_BHR;

    core_if_bp_if bus ();

    core_if_bp dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem                  (bus),
        .stall_pipeline_alu    (stall_pipeline_alu),
        .stall_pipeline_br     (stall_pipeline_br),
        .if_flush              (if_flush),
        .update_btb_target_out (update_btb_target_out),
        .btb_target_out        (btb_target_out),
        .btb_type_out          (btb_type_out),
        .update_BP_out         (update_BP_out),
        .taken                 (taken),
        .delayed_PHT_out       (delayed_PHT_out),
        .delayed_BHR_out       (delayed_BHR_out),
        .recover_push          (recover_push),
        .recover_push_addr     (recover_push_addr),
        .recover_pop           (recover_pop),
        .if_id_inst_word       (if_id_inst_word),
        .if_id_plus_4          (if_id_plus_4),
        .btb_v                 (btb_v),
        .btb_type              (btb_type),
        .pred_target           (pred_target),
        .delayed_PHT           (delayed_PHT),
        .delayed_BHR           (delayed_BHR)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] jr_exp [5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted fetch at pc_now; IF/ID contents are scoreboarded, then the redirect is checked.
    task automatic fetch(input logic [31:0] pc_now, input logic [31:0] npc, input logic bv,
                         input logic [1:0] typ, input logic [31:0] tgt);
        logic [63:0] e;
        check("pc", {32'd0, bus.imem_addr}, {32'd0, pc_now});
        bus.imem_rdy   = 1'b1;
        bus.imem_rdata = mem_word(pc_now);
        exp_q.push_back({mem_word(pc_now), pc_now + 32'd4});
        tick();
        e = exp_q.pop_front();
        check("ifid", {if_id_inst_word, if_id_plus_4}, e);
        check("btb_v", {63'd0, btb_v}, {63'd0, bv});
        if (bv) begin
            check("btb_type", {62'd0, btb_type}, {62'd0, typ});
            check("pred_target", {32'd0, pred_target}, {32'd0, tgt});
        end
        check("next_pc", {32'd0, bus.imem_addr}, {32'd0, npc});
    endtask

    task automatic flush_to(input logic [31:0] t);
        if_flush       = 1'b1;
        btb_target_out = t;
        tick();
        if_flush = 1'b0;
        check("flush_pc", {32'd0, bus.imem_addr}, {32'd0, t & 32'hFFFF_FFFC});
        check("flush_bubble", {if_id_inst_word, if_id_plus_4}, 64'd0);
    endtask

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef CORE_IF_RAS_EN
        jr_exp[0] = 32'h114; jr_exp[1] = 32'h110; jr_exp[2] = 32'h10C;
        jr_exp[3] = 32'h108; jr_exp[4] = 32'h3F0;
`else
        for (int k = 0; k < 5; k++) jr_exp[k] = 32'h3F0;
`endif
        stall_pipeline_alu = 0; stall_pipeline_br = 0; if_flush = 0;
        update_btb_target_out = 0; btb_target_out = 0; btb_type_out = 0;
        update_BP_out = 0; taken = 0; delayed_PHT_out = 0; delayed_BHR_out = 0;
        recover_push = 0; recover_pop = 0; recover_push_addr = 0;
        bus.imem_rdy = 1'b1; bus.imem_rdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", {32'd0, bus.imem_addr}, 64'd0);
        check("rst_req", {63'd0, bus.imem_req}, 64'd0);
        check("rst_ifid", {if_id_inst_word, if_id_plus_4}, 64'd0);
        check("rst_pred", {pred_target, 25'd0, btb_v, btb_type, delayed_PHT, delayed_BHR}, 64'd0);
        rst = 1'b1;
        #1;
        check("req_run", {63'd0, bus.imem_req}, 64'd1);

        // Sequential fetch
        for (int k = 0; k < 5; k++) fetch(32'(4 * k), 32'(4 * k + 4), 1'b0, 2'b00, 32'd0);

        // BTB write for 0x10 (in ID) during an imem wait, then refetch 0x10
        update_btb_target_out = 1; btb_type_out = 2'b01; btb_target_out = 32'h40;
        bus.imem_rdy = 1'b0;
        tick();
        update_btb_target_out = 0;
        check("wait_pc", {32'd0, bus.imem_addr}, 64'h14);
        check("wait_bubble", {32'd0, if_id_inst_word}, 64'd0);
        bus.imem_rdy = 1'b1;
        flush_to(32'h10);
        fetch(32'h10, 32'h40, 1'b1, 2'b01, 32'h40);
        fetch(32'h40, 32'h44, 1'b0, 2'b00, 32'd0);

        // Stall with a simultaneous flush: flush ignored while stalled
        stall_pipeline_br = 1; if_flush = 1; btb_target_out = 32'h200;
        #1;
        check("stall_req", {63'd0, bus.imem_req}, 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_pc", {32'd0, bus.imem_addr}, 64'h44);
            check("stall_ifid", {if_id_inst_word, if_id_plus_4}, {mem_word(32'h40), 32'h44});
        end
        stall_pipeline_br = 0;
        flush_to(32'h200);

        // imem not ready for three cycles
        bus.imem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rdy_pc", {32'd0, bus.imem_addr}, 64'h200);
            check("rdy_inst", {32'd0, if_id_inst_word}, 64'd0);
        end
        fetch(32'h200, 32'h204, 1'b0, 2'b00, 32'd0);

        // Under stall: BTB br entry for 0x200, then three taken trainings on PHT[0]
        stall_pipeline_alu = 1;
        update_btb_target_out = 1; btb_type_out = 2'b00; btb_target_out = 32'h300;
        tick();
        update_btb_target_out = 0;
        update_BP_out = 1; taken = 1; delayed_BHR_out = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            delayed_PHT_out = 2'(k);
            tick();
        end
        update_BP_out = 0;
        check("train_stall_pc", {32'd0, bus.imem_addr}, 64'h204);
        stall_pipeline_alu = 0;
        flush_to(32'h200);
        // BHR=111 selects untouched PHT[7]=01: branch predicted not taken
        fetch(32'h200, 32'h204, 1'b1, 2'b00, 32'h300);
        check("bhr_111", {61'd0, delayed_BHR}, 64'd7);
        check("pht7", {62'd0, delayed_PHT}, 64'd1);

        // Three not-taken trainings shift BHR back to 000 (PHT[5] saturates at 00)
        bus.imem_rdy = 1'b0;
        update_BP_out = 1; taken = 0; delayed_BHR_out = 3'd5; delayed_PHT_out = 2'b00;
        repeat (3) tick();
        update_BP_out = 0;
        bus.imem_rdy = 1'b1;
        flush_to(32'h200);
        fetch(32'h200, 32'h300, 1'b1, 2'b00, 32'h300);
        check("pht0_sat", {62'd0, delayed_PHT}, 64'd3);
        check("bhr_000", {61'd0, delayed_BHR}, 64'd0);

        // Unaligned redirect and pc+4 wrap
        flush_to(32'hFFFF_FFFF);
        fetch(32'hFFFF_FFFC, 32'h0, 1'b0, 2'b00, 32'd0);

        // Install jal at 0x100..0x110 (target pc+4) and jr at 0x120..0x130 (BTB target 0x3F0)
        flush_to(32'h100);
        for (int a = 32'h100; a <= 32'h134; a += 4) begin
            update_btb_target_out = 0;
            if (a - 4 >= 32'h100 && a - 4 <= 32'h110) begin
                update_btb_target_out = 1; btb_type_out = 2'b10; btb_target_out = 32'(a);
            end else if (a - 4 >= 32'h120 && a - 4 <= 32'h130) begin
                update_btb_target_out = 1; btb_type_out = 2'b11; btb_target_out = 32'h3F0;
            end
            fetch(32'(a), 32'(a + 4), 1'b0, 2'b00, 32'd0);
        end
        update_btb_target_out = 0;

        flush_to(32'h100);
        for (int k = 0; k < 5; k++)
            fetch(32'(32'h100 + 4 * k), 32'(32'h104 + 4 * k), 1'b1, 2'b10, 32'(32'h104 + 4 * k));
        for (int k = 0; k < 5; k++) begin
            flush_to(32'(32'h120 + 4 * k));
            fetch(32'(32'h120 + 4 * k), jr_exp[k], 1'b1, 2'b11, jr_exp[k]);
        end

        // Asynchronous reset mid-operation clears pc, IF/ID and the BTB
        #2;
        rst = 1'b0;
        #1;
        check("arst_pc", {32'd0, bus.imem_addr}, 64'd0);
        check("arst_ifid", {if_id_inst_word, if_id_plus_4}, 64'd0);
        check("arst_req", {63'd0, bus.imem_req}, 64'd0);
        tick();
        rst = 1'b1;
        fetch(32'h0, 32'h4, 1'b0, 2'b00, 32'd0);
        flush_to(32'h100);
        fetch(32'h100, 32'h104, 1'b0, 2'b00, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
